// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, samples each bit mid-period, and holds one byte
// behind a valid/ack handshake with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ack,
  output logic       rx_framing_error,
  output logic       rx_overrun
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          sync1_q, sync2_q;
  logic          rxd_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ovr_q, ovr_d;
  logic          stopGood, stopBad;

  assign rxd_s = sync2_q;

  // Sync flops reset to 1 so a reset never manufactures a false start edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    shift_d  = shift_q;
    stopGood = 1'b0;
    stopBad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_MID) begin
          if (!rxd_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = {rxd_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (rxd_s) begin
            stopGood = 1'b1;
            state_d  = S_IDLE;
          end else begin
            stopBad = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // A line held low reports one framing error, then waits for idle.
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A delivery arriving together with an ack replaces the held byte instead of clearing valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = stopBad;
    ovr_d   = 1'b0;
    if (stopGood) begin
      if (!valid_q || rx_data_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_data_ack) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data          = data_q;
  assign rx_data_valid    = valid_q;
  assign rx_framing_error = fe_q;
  assign rx_overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner sequences,
// with a byte scoreboard popped whenever the receiver delivers.
module tb_uart_rx;

  localparam int C       = 16;
  localparam int HALF    = C / 2;
  localparam int CBIG    = 5208;
  localparam int HALFBIG = CBIG / 2;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         gap;
    int         expFe;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rxData;
  logic       valid, fe, ovr;
  logic       rxdBig = 1'b1;
  logic       ackBig = 1'b0;
  logic [7:0] rxDataBig;
  logic       validBig, feBig, ovrBig;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   feCount = 0;
  int   ovrCount = 0;
  int   riseCycle = -1;
  int   bigRise = -1;
  int   feBigCount = 0;
  bit   autoAck = 1'b0;
  bit   manualAck = 1'b0;
  logic [7:0] sbQ[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .rx_data(rxData), .rx_data_valid(valid), .rx_data_ack(ack),
    .rx_framing_error(fe), .rx_overrun(ovr)
  );

  uart_rx #(.CLKS_PER_BIT(CBIG)) dutBig (
    .clk(clk), .reset(reset), .rxd(rxdBig),
    .rx_data(rxDataBig), .rx_data_valid(validBig), .rx_data_ack(ackBig),
    .rx_framing_error(feBig), .rx_overrun(ovrBig)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  // Ack is the consumer: either follows valid (auto) or a hand-driven level.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ack = autoAck ? valid : manualAck;
    end
  end

  // Small-DUT monitor: counts pulses and pops the scoreboard on every delivery.
  initial begin
    logic       lastValid;
    logic       lastAck;
    logic [7:0] expByte;
    lastValid = 1'b0;
    lastAck   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (fe) feCount++;
        if (ovr) ovrCount++;
        if (fe || ovr) checkOutput("pulseOverlap", int'(fe && ovr), 0);
        if (valid && !lastValid) riseCycle = cyc;
        if (valid && (!lastValid || lastAck)) begin
          checkOutput("sbNotEmpty", int'(sbQ.size() > 0), 1);
          if (sbQ.size() > 0) begin
            expByte = sbQ.pop_front();
            checkOutput("sbByte", int'(rxData), int'(expByte));
          end
        end
      end
      lastValid = valid;
      lastAck   = ack;
    end
  end

  initial begin
    logic lastValidBig;
    lastValidBig = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (feBig) feBigCount++;
        if (validBig && !lastValidBig) bigRise = cyc;
      end
      lastValidBig = validBig;
    end
  end

  // Drives one frame slot per clock; a window >= 0 keeps each bit correct only
  // within +/-win cycles of its mid-point and inverted elsewhere.
  task automatic applyStimulus(input bit big, input logic [7:0] data, input logic stopVal,
                               input int win, input int nSlots, output int startCyc);
    int   c, h, b, off;
    logic nom, v;
    c = big ? CBIG : C;
    h = big ? HALFBIG : HALF;
    startCyc = 0;
    for (int s = 0; s < nSlots; s++) begin
      @(posedge clk);
      #1;
      if (s == 0) startCyc = cyc;
      b   = s / c;
      off = s % c;
      if (b == 0) nom = 1'b0;
      else if (b <= 8) nom = data[b-1];
      else nom = stopVal;
      v = nom;
      if (win >= 0 && (off < h - win || off > h + win)) begin
        if (b == 0 && off == 0) v = 1'b0;
        else if (b == 9 && off > h + win) v = 1'b1;
        else v = ~nom;
      end
      if (big) rxdBig = v;
      else rxd = v;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rxd = 1'b1;
    end
  endtask

  task automatic pulseAck();
    manualAck = 1'b1;
    @(posedge clk);
    #1;
    manualAck = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs[5];
    int   n, feBefore, ovrBefore, waited;

    vecs[0] = '{data: 8'h3C, stopBit: 1'b0, gap: C, expFe: 1};
    vecs[1] = '{data: 8'h5A, stopBit: 1'b1, gap: C, expFe: 0};
    vecs[2] = '{data: 8'h00, stopBit: 1'b1, gap: 0, expFe: 0};
    vecs[3] = '{data: 8'hFF, stopBit: 1'b1, gap: 0, expFe: 0};
    vecs[4] = '{data: 8'h81, stopBit: 1'b1, gap: C, expFe: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetData", int'(rxData), 0);
    checkOutput("resetValid", int'(valid), 0);
    checkOutput("resetFe", int'(fe), 0);
    checkOutput("resetOvr", int'(ovr), 0);
    checkOutput("resetValidBig", int'(validBig), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(C);

    // A5 with bits valid only around their mid-points, ack held low.
    sbQ.push_back(8'hA5);
    applyStimulus(1'b0, 8'hA5, 1'b1, 2, 10 * C, n);
    idle(C);
    checkOutput("a5Latency", riseCycle, n + 3 + HALF + 9 * C);
    checkOutput("a5Valid", int'(valid), 1);
    checkOutput("a5Data", int'(rxData), 8'hA5);
    checkOutput("a5Fe", feCount, 0);
    checkOutput("a5Ovr", ovrCount, 0);
    pulseAck();
    checkOutput("a5AckClears", int'(valid), 0);

    // Short low glitch must be rejected at the start-bit sample.
    idle(1);
    repeat (4) begin
      @(posedge clk);
      #1;
      rxd = 1'b0;
    end
    idle(2 * C);
    checkOutput("glitchValid", int'(valid), 0);
    checkOutput("glitchFe", feCount, 0);
    checkOutput("glitchOvr", ovrCount, 0);

    autoAck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      feBefore  = feCount;
      ovrBefore = ovrCount;
      if (vecs[i].stopBit) sbQ.push_back(vecs[i].data);
      applyStimulus(1'b0, vecs[i].data, vecs[i].stopBit, -1, 10 * C, n);
      idle(vecs[i].gap);
      checkOutput($sformatf("vec%0dFe", i), feCount - feBefore, vecs[i].expFe);
      checkOutput($sformatf("vec%0dOvr", i), ovrCount - ovrBefore, 0);
    end
    idle(C);
    checkOutput("tableSbDrained", sbQ.size(), 0);

    // Overrun: second byte arrives while the first is still held.
    autoAck = 1'b0;
    manualAck = 1'b0;
    idle(2);
    feBefore  = feCount;
    ovrBefore = ovrCount;
    sbQ.push_back(8'h11);
    applyStimulus(1'b0, 8'h11, 1'b1, -1, 10 * C, n);
    idle(C);
    applyStimulus(1'b0, 8'h22, 1'b1, -1, 10 * C, n);
    idle(C);
    checkOutput("ovrPulses", ovrCount - ovrBefore, 1);
    checkOutput("ovrFe", feCount - feBefore, 0);
    checkOutput("ovrValid", int'(valid), 1);
    checkOutput("ovrData", int'(rxData), 8'h11);
    @(posedge clk);
    #1;
    pulseAck();
    checkOutput("ovrAckClears", int'(valid), 0);
    pulseAck();
    checkOutput("idleAckValid", int'(valid), 0);
    checkOutput("idleAckData", int'(rxData), 8'h11);

    // Reset in the middle of a frame while a byte is held.
    sbQ.push_back(8'h66);
    applyStimulus(1'b0, 8'h66, 1'b1, -1, 10 * C, n);
    idle(C);
    checkOutput("preResetValid", int'(valid), 1);
    applyStimulus(1'b0, 8'h77, 1'b1, -1, 4 * C, n);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midResetData", int'(rxData), 0);
    checkOutput("midResetValid", int'(valid), 0);
    checkOutput("midResetFe", int'(fe), 0);
    checkOutput("midResetOvr", int'(ovr), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2 * C);
    autoAck = 1'b1;
    sbQ.push_back(8'h42);
    applyStimulus(1'b0, 8'h42, 1'b1, -1, 10 * C, n);
    idle(C);
    checkOutput("postResetSbDrained", sbQ.size(), 0);
    checkOutput("postResetData", int'(rxData), 8'h42);
    checkOutput("totalFe", feCount, 1);

    // Full-rate instance: bits held correct only near their expected sample points.
    applyStimulus(1'b1, 8'hC3, 1'b1, 3, 10 * CBIG, n);
    waited = 0;
    while (!validBig && waited < 2 * CBIG) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    checkOutput("bigValid", int'(validBig), 1);
    checkOutput("bigLatency", bigRise, n + 3 + HALFBIG + 9 * CBIG);
    checkOutput("bigData", int'(rxDataBig), 8'hC3);
    checkOutput("bigFe", feBigCount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
